// File: rtl/serial_borrow_subtractor.sv
// Multi-cycle ripple-borrow subtractor: Number1 - Number2 - Borrow, CHUNK bits per clock, N+2 cycles per op.
// Optional signed-overflow output is built only when SERIAL_SUB_OVERFLOW_EN is defined.
module serial_borrow_subtractor #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
) (
    input  logic             Clk_i,
    input  logic             Rst_i,
    input  logic             Start_i,
    input  logic [WIDTH-1:0] Number1_i,
    input  logic [WIDTH-1:0] Number2_i,
    input  logic             Borrow_i,
    output logic             Busy_o,
    output logic             Done_o,
    output logic [WIDTH-1:0] Result_o,
`ifdef SERIAL_SUB_OVERFLOW_EN
    output logic             Overflow_o,
`endif
    output logic             Borrow_o
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] op1_q, op1_d;
    logic [WIDTH-1:0] op2_q, op2_d;
    logic             brw_q, brw_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             borrow_q, borrow_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_diff;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        brw_d    = brw_q;
        shadow_d = shadow_q;
        result_d = result_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;

        a_chunk = op1_q[cnt_q*CHUNK +: CHUNK];
        b_chunk = op2_q[cnt_q*CHUNK +: CHUNK];
        // The extra top bit goes negative exactly when this chunk needs a borrow.
        chunk_diff = {1'b0, a_chunk} - {1'b0, b_chunk} - {{CHUNK{1'b0}}, brw_q};

        case (state_q)
            IDLE: begin
                if (Start_i) begin
                    op1_d   = Number1_i;
                    op2_d   = Number2_i;
                    brw_d   = Borrow_i;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                shadow_d[cnt_q*CHUNK +: CHUNK] = chunk_diff[CHUNK-1:0];
                brw_d = chunk_diff[CHUNK];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d  = DONE;
                    cnt_d    = '0;
                    result_d = shadow_d;
                    borrow_d = chunk_diff[CHUNK];
                    ovf_d    = (op1_q[WIDTH-1] != op2_q[WIDTH-1]) &&
                               (shadow_d[WIDTH-1] != op1_q[WIDTH-1]);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            brw_q    <= 1'b0;
            shadow_q <= '0;
            result_q <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            brw_q    <= brw_d;
            shadow_q <= shadow_d;
            result_q <= result_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    assign Busy_o   = busy_q;
    assign Done_o   = done_q;
    assign Result_o = result_q;
    assign Borrow_o = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    assign Overflow_o = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Directed plus randomized bench for serial_borrow_subtractor at WIDTH=16, CHUNK=4.
module tb_serial_borrow_subtractor;

    localparam int W = 16;
    localparam int C = 4;
    localparam int N = W / C;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] num1 = '0;
    logic [W-1:0] num2 = '0;
    logic         bin = 1'b0;
    logic         busy, done, bout;
    logic [W-1:0] res;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic         ovf;
`endif

    int checks = 0;
    int failures = 0;
    logic [W-1:0] prev_res = '0;
    logic         prev_bout = 1'b0;

    always #5 clk = ~clk;

    serial_borrow_subtractor #(.WIDTH(W), .CHUNK(C)) dut (
        .Clk_i(clk),
        .Rst_i(rst),
        .Start_i(start),
        .Number1_i(num1),
        .Number2_i(num2),
        .Borrow_i(bin),
        .Busy_o(busy),
        .Done_o(done),
        .Result_o(res),
`ifdef SERIAL_SUB_OVERFLOW_EN
        .Overflow_o(ovf),
`endif
        .Borrow_o(bout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch one operation at the next edge and follow it through to the return to IDLE.
    task automatic do_op(input logic [W-1:0] n1, input logic [W-1:0] n2, input logic b,
                         input bit poke, input string tag);
        int          edges;
        int          diff;
        logic [W-1:0] exp_r;
        logic        exp_b;
        diff  = int'(n1) - int'(n2) - int'(b);
        exp_r = W'(diff);
        exp_b = (diff < 0);
        start = 1'b1; num1 = n1; num2 = n2; bin = b;
        @(posedge clk); #1;
        start = 1'b0;
        num1 = W'($urandom); num2 = W'($urandom); bin = 1'($urandom);
        check({tag, "_busy_rise"}, 32'(busy), 32'd1);
        edges = 0;
        while (!done && edges < 20) begin
            check({tag, "_res_held"}, 32'(res), 32'(prev_res));
            check({tag, "_bout_held"}, 32'(bout), 32'(prev_bout));
            if (poke && edges < 3) begin
                start = 1'b1;
                num1 = W'($urandom); num2 = W'($urandom); bin = 1'($urandom);
            end
            @(posedge clk); #1;
            start = 1'b0;
            edges++;
        end
        check({tag, "_done_latency"}, 32'(edges), 32'(N));
        check({tag, "_result"}, 32'(res), 32'(exp_r));
        check({tag, "_borrow"}, 32'(bout), 32'(exp_b));
`ifdef SERIAL_SUB_OVERFLOW_EN
        check({tag, "_ovf"}, 32'(ovf),
              32'((n1[W-1] != n2[W-1]) && (exp_r[W-1] != n1[W-1])));
`endif
        check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
        prev_res  = exp_r;
        prev_bout = exp_b;
        @(posedge clk); #1;
        check({tag, "_done_pulse_end"}, 32'(done), 32'd0);
        check({tag, "_busy_fall"}, 32'(busy), 32'd0);
        check({tag, "_res_hold_after"}, 32'(res), 32'(exp_r));
    endtask

    initial begin
        #12;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", 32'(res), 32'd0);
        check("reset_borrow", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
        check("reset_ovf", 32'(ovf), 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(16'd3476, 16'd986, 1'b0, 1'b0, "basic");
        do_op(16'd15, 16'd25, 1'b0, 1'b0, "underflow");
        do_op(16'd0, 16'd0, 1'b1, 1'b0, "zero_bin");
        do_op(16'h1000, 16'h0001, 1'b1, 1'b0, "ripple");
        do_op(16'h1234, 16'h0234, 1'b0, 1'b1, "ignored_starts");
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, "b2b_max");

        // Reset two RUN cycles into an operation.
        start = 1'b1; num1 = 16'hABCD; num2 = 16'h0123; bin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrun_rst_busy", 32'(busy), 32'd0);
        check("midrun_rst_done", 32'(done), 32'd0);
        check("midrun_rst_result", 32'(res), 32'd0);
        check("midrun_rst_borrow", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
        check("midrun_rst_ovf", 32'(ovf), 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("post_rst_no_done", 32'(done), 32'd0);
            @(posedge clk); #1;
        end
        check("post_rst_idle", 32'(busy), 32'd0);
        prev_res  = '0;
        prev_bout = 1'b0;
        do_op(16'd100, 16'd1, 1'b0, 1'b0, "after_reset");

`ifdef SERIAL_SUB_OVERFLOW_EN
        do_op(16'h8000, 16'h0001, 1'b0, 1'b0, "ovf_set");
        check("ovf_set_value", 32'(ovf), 32'd1);
        do_op(16'd5, 16'd3, 1'b0, 1'b0, "ovf_clear");
        check("ovf_clear_value", 32'(ovf), 32'd0);
`endif

        for (int i = 0; i < 24; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)), "random");
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
